// File: rtl/factorizer_seq.sv
// Handshaked trial-division factorizer: the number is streamed MSB first into one
// residue register per divisor 2..MAX_DIV, and the zero residues form the result.
module factorizer_seq #(
    parameter int WIDTH   = 16,
    parameter int MAX_DIV = 19,
    parameter int RW      = $clog2(MAX_DIV),
    parameter int CW      = $clog2(MAX_DIV + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   number,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAX_DIV-2:0] factors,
    output logic [CW-1:0]      factor_count,
    output logic [CW-1:0]      smallest
);

    localparam int NF = MAX_DIV - 1;
    localparam int NW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [NW-1:0]    cnt;
    logic [NF-1:0]    zero_vec;
    logic             accept;

    // r < d guarantees t = 2r+b < 2d, so a single conditional subtract keeps r < d.
    function automatic logic [RW-1:0] mod_step(input logic [RW-1:0] r,
                                               input logic          b,
                                               input logic [RW:0]   d);
        logic [RW:0] t;
        t = {r, b};
        if (t >= d) begin
            t = t - d;
        end
        return t[RW-1:0];
    endfunction

    function automatic logic [CW-1:0] pop_count(input logic [NF-1:0] z);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NF; i++) begin
            if (z[i]) begin
                c = c + 1'b1;
            end
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] lowest_div(input logic [NF-1:0] z);
        logic [CW-1:0] s;
        s = '0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (z[i]) begin
                s = CW'(i + 2);
            end
        end
        return s;
    endfunction

    assign in_ready = (state == S_IDLE);
    assign accept   = (state == S_IDLE) && in_valid;

    for (genvar g = 0; g < NF; g++) begin : g_div
        localparam logic [RW:0] D = (RW + 1)'(g + 2);
        logic [RW-1:0] r;

        always_ff @(posedge clk) begin
            if (reset) begin
                r <= '0;
            end else if (accept) begin
                r <= '0;
            end else if (state == S_RUN) begin
                r <= mod_step(r, shreg[WIDTH-1], D);
            end
        end

        assign zero_vec[g] = (r == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            shreg        <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            factors      <= '0;
            factor_count <= '0;
            smallest     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg <= number;
                        cnt   <= NW'(WIDTH);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    if (cnt == NW'(1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    factors      <= zero_vec;
                    factor_count <= pop_count(zero_vec);
                    smallest     <= lowest_div(zero_vec);
                    out_valid    <= 1'b1;
                    state        <= S_DONE;
                end
                default: begin
                    // Result registers are left untouched so they hold under backpressure.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factorizer_seq.sv
// Bench for factorizer_seq: fixed vectors, backpressure and mid-run reset sequences,
// and random numbers checked against a modulo-based reference model.
module tb_factorizer_seq;

    localparam int WIDTH   = 16;
    localparam int MAX_DIV = 19;
    localparam int CW      = $clog2(MAX_DIV + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   number;
    logic               out_valid;
    logic               out_ready;
    logic [MAX_DIV-2:0] factors;
    logic [CW-1:0]      factor_count;
    logic [CW-1:0]      smallest;

    int checks = 0;
    int errors = 0;

    factorizer_seq #(.WIDTH(WIDTH), .MAX_DIV(MAX_DIV)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .number(number),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .factors(factors),
        .factor_count(factor_count),
        .smallest(smallest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   num;
        logic [MAX_DIV-2:0] fac;
        logic [CW-1:0]      cnt;
        logic [CW-1:0]      sm;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modulo for every divisor.
    function automatic void model(input int n, output logic [MAX_DIV-2:0] f,
                                  output logic [CW-1:0] c, output logic [CW-1:0] s);
        f = '0;
        c = '0;
        s = '0;
        for (int d = MAX_DIV; d >= 2; d--) begin
            if (n % d == 0) begin
                f[d-2] = 1'b1;
                c = c + 1'b1;
                s = CW'(d);
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [WIDTH-1:0] n);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        number   = n;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic transact(input logic [WIDTH-1:0] n, input int hold,
                            output logic [MAX_DIV-2:0] fac, output logic [CW-1:0] cnt,
                            output logic [CW-1:0] sm);
        int e;
        out_ready = (hold == 0);
        send(n);
        e = 0;
        while (!out_valid && e < 100) begin
            @(negedge clk);
            e++;
        end
        // Edges after the accept edge: WIDTH in RUN plus the FIN edge.
        check("latency", e, WIDTH + 1);
        fac = factors;
        cnt = factor_count;
        sm  = smallest;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            number   = 16'd7;
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_factors", {14'd0, factors}, {14'd0, fac});
            check("hold_count", {27'd0, factor_count}, {27'd0, cnt});
            check("hold_smallest", {27'd0, smallest}, {27'd0, sm});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [MAX_DIV-2:0] f, mf;
        logic [CW-1:0]      c, s, mc, ms;
        logic [WIDTH-1:0]   n;
        int                 hold;

        tbl[0] = '{16'd360,   18'h125DF, 5'd11, 5'd2};
        tbl[1] = '{16'd221,   18'h08800, 5'd2,  5'd13};
        tbl[2] = '{16'd1,     18'h00000, 5'd0,  5'd0};
        tbl[3] = '{16'd0,     18'h3FFFF, 5'd18, 5'd2};
        tbl[4] = '{16'd65535, 18'h0A00A, 5'd4,  5'd3};
        tbl[5] = '{16'd7,     18'h00020, 5'd1,  5'd7};
        tbl[6] = '{16'd17,    18'h08000, 5'd1,  5'd17};
        tbl[7] = '{16'd19,    18'h20000, 5'd1,  5'd19};

        reset     = 1'b1;
        in_valid  = 1'b0;
        number    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_factors", {14'd0, factors}, 32'd0);
        check("rst_count", {27'd0, factor_count}, 32'd0);
        check("rst_smallest", {27'd0, smallest}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            transact(tbl[i].num, 0, f, c, s);
            check("vec_factors", {14'd0, f}, {14'd0, tbl[i].fac});
            check("vec_count", {27'd0, c}, {27'd0, tbl[i].cnt});
            check("vec_smallest", {27'd0, s}, {27'd0, tbl[i].sm});
        end

        // Backpressure with in_valid pulses of 7 that must be ignored.
        transact(16'd360, 10, f, c, s);
        check("bp_factors", {14'd0, f}, {14'd0, 18'h125DF});
        repeat (3) @(negedge clk);
        check("bp_no_capture", {31'd0, in_ready}, 32'd1);
        transact(16'd7, 0, f, c, s);
        check("bp7_factors", {14'd0, f}, {14'd0, 18'h00020});
        check("bp7_count", {27'd0, c}, 32'd1);
        check("bp7_smallest", {27'd0, s}, 32'd7);

        // Reset in the middle of a run discards the number.
        out_ready = 1'b1;
        send(16'd360);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_factors", {14'd0, factors}, 32'd0);
        check("mid_rst_count", {27'd0, factor_count}, 32'd0);
        check("mid_rst_smallest", {27'd0, smallest}, 32'd0);
        repeat (WIDTH + 4) @(negedge clk);
        check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        transact(16'd17, 0, f, c, s);
        check("rst17_factors", {14'd0, f}, {14'd0, 18'h08000});
        check("rst17_count", {27'd0, c}, 32'd1);
        check("rst17_smallest", {27'd0, s}, 32'd17);

        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) n = WIDTH'($urandom_range(0, 3640) * 18);
            else n = WIDTH'($urandom_range(0, 65535));
            hold = $urandom_range(0, 3);
            model(int'(n), mf, mc, ms);
            transact(n, hold, f, c, s);
            check("rand_factors", {14'd0, f}, {14'd0, mf});
            check("rand_count", {27'd0, c}, {27'd0, mc});
            check("rand_smallest", {27'd0, s}, {27'd0, ms});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
